hough_lane_select: RTL and testbench

Parametrised lane-selection stage placed after the Hough accumulator in the lane-detection pipeline. It drains the accumulator as a stream of `THETA_UNROLL`-wide vote beats and tracks the strongest bin inside two configurable theta windows, one for the left lane and one for the right lane. When the scan ends it reports a `(rho, theta)` pair and a valid flag per lane. It supersedes the fixed single-window peak logic: unroll width, accumulator geometry and both windows are parameters.

---
 rtl/hough_lane_select_if.sv | 34 +++
 rtl/hough_lane_select.sv | 218 +++++++++++++++++++++
 tb/tb_hough_lane_select.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/hough_lane_select_if.sv
// hough_lane_select_if: start/FIFO-pop stream plus per-lane result bundle.
// master drives the scan and source FIFO; slave is the lane selector.
interface hough_lane_select_if #(
    parameter int THETA_UNROLL     = 16,
    parameter int ACCUM_BUFF_WIDTH = 8,
    parameter int THETA_BITS       = 9
);
    logic                                     start;
    logic                                     in_empty;
    logic                                     in_rd_en;
    logic [THETA_UNROLL*ACCUM_BUFF_WIDTH-1:0] in_dout;
    logic signed [15:0]                       left_rho_out;
    logic signed [15:0]                       right_rho_out;
    logic [THETA_BITS-1:0]                    left_theta_out;
    logic [THETA_BITS-1:0]                    right_theta_out;
    logic                                     left_valid;
    logic                                     right_valid;
    logic                                     busy;
    logic                                     done;

    modport master (
        output start, in_empty, in_dout,
        input  in_rd_en, left_rho_out, right_rho_out,
        input  left_theta_out, right_theta_out,
        input  left_valid, right_valid, busy, done
    );

    modport slave (
        input  start, in_empty, in_dout,
        output in_rd_en, left_rho_out, right_rho_out,
        output left_theta_out, right_theta_out,
        output left_valid, right_valid, busy, done
    );
endinterface

// File: rtl/hough_lane_select.sv
// hough_lane_select: per-window strongest Hough bin for left/right lanes.
// Optional HOUGH_VOTE_THRESH_EN: valid needs best_count >= VOTE_THRESH.
module hough_lane_select #(
    parameter int THETA_UNROLL     = 16,
    parameter int NUM_THETA        = 180,
    parameter int THETA_BITS       = 9,
    parameter int NUM_RHO          = 1024,
    parameter int RHO_OFFSET       = 512,
    parameter int ACCUM_BUFF_WIDTH = 8,
    parameter int LEFT_THETA_MIN   = 20,
    parameter int LEFT_THETA_MAX   = 70,
    parameter int RIGHT_THETA_MIN  = 110,
    parameter int RIGHT_THETA_MAX  = 160,
    parameter int VOTE_THRESH      = 32
) (
    input logic              clock,
    input logic              reset,
    hough_lane_select_if.slave io
);
    localparam int G  = (NUM_THETA + THETA_UNROLL - 1) / THETA_UNROLL;
    localparam int RW = (NUM_RHO > 1) ? $clog2(NUM_RHO) : 1;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int VW = ACCUM_BUFF_WIDTH;
    localparam int TW = THETA_BITS;

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN1, DRAIN2, DONE} state_t;

    state_t                     state_q;
    logic [RW-1:0]              row_q;
    logic [GW-1:0]              grp_q;
    logic [THETA_UNROLL*VW-1:0] s1_beat_q;
    logic [RW-1:0]              s1_row_q, s2_row_q;
    logic [GW-1:0]              s1_grp_q;
    logic                       s1_vld_q, s2_vld_q;
    logic [VW-1:0]              s2_lcnt_q, s2_rcnt_q;
    logic [TW-1:0]              s2_lth_q, s2_rth_q;
    logic [VW-1:0]              lcnt_q, rcnt_q, lcnt_d, rcnt_d;
    logic [RW-1:0]              lrow_q, rrow_q, lrow_d, rrow_d;
    logic [TW-1:0]              lth_q, rth_q, lth_d, rth_d;
    logic [VW-1:0]              lmax, rmax, v;
    logic [TW-1:0]              lmax_th, rmax_th;
    int                         th;
    logic                       lval_d, rval_d;
    logic signed [15:0]         lrho_d, rrho_d, lrho_q, rrho_q;
    logic [TW-1:0]              lto_d, rto_d, lto_q, rto_q;
    logic                       lval_q, rval_q, busy_q, done_q;
    logic                       pop, last_beat;

    assign pop       = (state_q == SCAN) && !io.in_empty;
    assign last_beat = (int'(row_q) == NUM_RHO - 1) && (int'(grp_q) == G - 1);

    assign io.in_rd_en        = pop;
    assign io.left_rho_out    = lrho_q;
    assign io.right_rho_out   = rrho_q;
    assign io.left_theta_out  = lto_q;
    assign io.right_theta_out = rto_q;
    assign io.left_valid      = lval_q;
    assign io.right_valid     = rval_q;
    assign io.busy            = busy_q;
    assign io.done            = done_q;

    // Strict '>' keeps the lowest lane on ties; padding lanes never match.
    always_comb begin
        lmax    = '0;
        rmax    = '0;
        lmax_th = '0;
        rmax_th = '0;
        th      = 0;
        v       = '0;
        for (int k = 0; k < THETA_UNROLL; k++) begin
            th = int'(s1_grp_q) * THETA_UNROLL + k;
            v  = s1_beat_q[k*VW +: VW];
            if (th < NUM_THETA) begin
                if (th >= LEFT_THETA_MIN && th <= LEFT_THETA_MAX && v > lmax) begin
                    lmax    = v;
                    lmax_th = TW'(th);
                end
                if (th >= RIGHT_THETA_MIN && th <= RIGHT_THETA_MAX && v > rmax) begin
                    rmax    = v;
                    rmax_th = TW'(th);
                end
            end
        end
    end

    always_comb begin
        lcnt_d = lcnt_q;
        lrow_d = lrow_q;
        lth_d  = lth_q;
        rcnt_d = rcnt_q;
        rrow_d = rrow_q;
        rth_d  = rth_q;
        if (s2_vld_q && s2_lcnt_q > lcnt_q) begin
            lcnt_d = s2_lcnt_q;
            lrow_d = s2_row_q;
            lth_d  = s2_lth_q;
        end
        if (s2_vld_q && s2_rcnt_q > rcnt_q) begin
            rcnt_d = s2_rcnt_q;
            rrow_d = s2_row_q;
            rth_d  = s2_rth_q;
        end
        lrho_d = 16'(int'(lrow_d) - RHO_OFFSET);
        rrho_d = 16'(int'(rrow_d) - RHO_OFFSET);
        lto_d  = lth_d;
        rto_d  = rth_d;
`ifdef HOUGH_VOTE_THRESH_EN
        lval_d = int'(lcnt_d) >= VOTE_THRESH;
        rval_d = int'(rcnt_d) >= VOTE_THRESH;
        if (!lval_d) begin
            lrho_d = '0;
            lto_d  = '0;
        end
        if (!rval_d) begin
            rrho_d = '0;
            rto_d  = '0;
        end
`else
        lval_d = lcnt_d != '0;
        rval_d = rcnt_d != '0;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            grp_q     <= '0;
            s1_beat_q <= '0;
            s1_row_q  <= '0;
            s1_grp_q  <= '0;
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_row_q  <= '0;
            s2_lcnt_q <= '0;
            s2_rcnt_q <= '0;
            s2_lth_q  <= '0;
            s2_rth_q  <= '0;
            lcnt_q    <= '0;
            lrow_q    <= '0;
            lth_q     <= '0;
            rcnt_q    <= '0;
            rrow_q    <= '0;
            rth_q     <= '0;
            lrho_q    <= '0;
            rrho_q    <= '0;
            lto_q     <= '0;
            rto_q     <= '0;
            lval_q    <= 1'b0;
            rval_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            s1_vld_q <= pop;
            if (pop) begin
                s1_beat_q <= io.in_dout;
                s1_row_q  <= row_q;
                s1_grp_q  <= grp_q;
            end
            s2_vld_q  <= s1_vld_q;
            s2_row_q  <= s1_row_q;
            s2_lcnt_q <= lmax;
            s2_lth_q  <= lmax_th;
            s2_rcnt_q <= rmax;
            s2_rth_q  <= rmax_th;
            lcnt_q    <= lcnt_d;
            lrow_q    <= lrow_d;
            lth_q     <= lth_d;
            rcnt_q    <= rcnt_d;
            rrow_q    <= rrow_d;
            rth_q     <= rth_d;

            unique case (state_q)
                IDLE, DONE: begin
                    if (io.start) begin
                        state_q  <= SCAN;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        row_q    <= '0;
                        grp_q    <= '0;
                        s1_vld_q <= 1'b0;
                        s2_vld_q <= 1'b0;
                        lcnt_q   <= '0;
                        lrow_q   <= '0;
                        lth_q    <= '0;
                        rcnt_q   <= '0;
                        rrow_q   <= '0;
                        rth_q    <= '0;
                    end
                end
                SCAN: begin
                    if (pop) begin
                        if (int'(grp_q) == G - 1) begin
                            grp_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            grp_q <= grp_q + 1'b1;
                        end
                        if (last_beat) state_q <= DRAIN1;
                    end
                end
                DRAIN1: state_q <= DRAIN2;
                DRAIN2: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    lrho_q  <= lrho_d;
                    rrho_q  <= rrho_d;
                    lto_q   <= lto_d;
                    rto_q   <= rto_d;
                    lval_q  <= lval_d;
                    rval_q  <= rval_d;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hough_lane_select.sv
// tb_hough_lane_select: directed images streamed through a FWFT source,
// results checked against hand-computed lane peaks.
module tb_hough_lane_select;
    localparam int U     = 16;
    localparam int NT    = 180;
    localparam int TB    = 9;
    localparam int NR    = 640;
    localparam int VW    = 8;
    localparam int G     = (NT + U - 1) / U;
    localparam int TOTAL = NR * G;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   nchk  = 0;
    int   nerr  = 0;

    always #5 clock = ~clock;

    hough_lane_select_if #(
        .THETA_UNROLL(U), .ACCUM_BUFF_WIDTH(VW), .THETA_BITS(TB)
    ) ifc ();

    hough_lane_select #(
        .THETA_UNROLL(U), .NUM_THETA(NT), .THETA_BITS(TB),
        .NUM_RHO(NR), .ACCUM_BUFF_WIDTH(VW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io   (ifc)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] vote(input int mode, input int row, input int th);
        case (mode)
            0: return (row == 600 && th == 30) ? 8'd200 : 8'd0;
            1: begin
                if (row == 10 && (th == 40 || th == 45 || th == 120)) return 8'd99;
                if (row == 20 && th == 120) return 8'd99;
                if (row == 5 && th == 90) return 8'd250;
                return 8'd0;
            end
            2: begin
                if (th >= 180) return 8'd255;
                if (row == 300 && th == 150) return 8'd5;
                return 8'd0;
            end
            default: begin
                if (row == 100 && th == 50) return 8'd31;
                if (row == 500 && th == 130) return 8'd32;
                return 8'd0;
            end
        endcase
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd_en"}, ifc.in_rd_en, 0);
        chk({tag, "_busy"}, ifc.busy, 0);
        chk({tag, "_done"}, ifc.done, 0);
        chk({tag, "_lvalid"}, ifc.left_valid, 0);
        chk({tag, "_rvalid"}, ifc.right_valid, 0);
        chk({tag, "_lrho"}, $signed(ifc.left_rho_out), 0);
        chk({tag, "_rtheta"}, ifc.right_theta_out, 0);
    endtask

    task automatic run_scan(input int mode, input bit bp, input int abort_at,
                            input int hold_lth, input bit poke_start);
        logic [U*VW-1:0] beat;
        int  idx   = 0;
        int  guard = 0;
        int  viol  = 0;
        bit  pop;
        ifc.start = 1'b1;
        @(negedge clock);
        ifc.start = 1'b0;
        chk("busy_after_start", ifc.busy, 1);
        if (hold_lth >= 0) chk("hold_ltheta", ifc.left_theta_out, hold_lth);
        while (idx < TOTAL && guard < TOTAL * 4 + 100) begin
            guard++;
            for (int k = 0; k < U; k++)
                beat[k*VW +: VW] = vote(mode, idx / G, (idx % G) * U + k);
            ifc.in_dout  = beat;
            ifc.in_empty = bp ? 1'($urandom_range(0, 1)) : 1'b0;
            ifc.start    = poke_start && idx == 100;
            #1;
            if (ifc.in_rd_en && ifc.in_empty) viol++;
            pop = ifc.in_rd_en && !ifc.in_empty;
            if (abort_at >= 0 && idx == abort_at) begin
                reset = 1'b0;
                #1;
                chk_reset_vals("abort");
                @(negedge clock);
                ifc.in_empty = 1'b1;
                reset = 1'b1;
                return;
            end
            @(posedge clock);
            if (pop) idx++;
            @(negedge clock);
        end
        ifc.in_empty = 1'b1;
        ifc.start    = 1'b0;
        chk("scan_completed_beats", idx, TOTAL);
        if (bp) chk("no_rd_while_empty", viol, 0);
        chk("done_T1", ifc.done, 0);
        @(negedge clock);
        chk("done_T2", ifc.done, 0);
        @(negedge clock);
        chk("done_T3", ifc.done, 1);
        chk("busy_at_done", ifc.busy, 0);
    endtask

    task automatic chk_single(input string tag);
        chk({tag, "_lrho"}, $signed(ifc.left_rho_out), 88);
        chk({tag, "_ltheta"}, ifc.left_theta_out, 30);
        chk({tag, "_lvalid"}, ifc.left_valid, 1);
        chk({tag, "_rvalid"}, ifc.right_valid, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        ifc.start    = 1'b0;
        ifc.in_empty = 1'b1;
        ifc.in_dout  = '0;
        #12;
        chk_reset_vals("reset");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        run_scan(0, 1'b0, -1, -1, 1'b0);
        chk_single("single");

        run_scan(1, 1'b0, -1, 30, 1'b1);
        chk("tie_lrho", $signed(ifc.left_rho_out), -502);
        chk("tie_ltheta", ifc.left_theta_out, 40);
        chk("tie_rrho", $signed(ifc.right_rho_out), -502);
        chk("tie_rtheta", ifc.right_theta_out, 120);
        chk("tie_rvalid", ifc.right_valid, 1);

        run_scan(2, 1'b0, -1, -1, 1'b0);
        chk("pad_rtheta", ifc.right_theta_out, 150);
        chk("pad_rrho", $signed(ifc.right_rho_out), -212);
        chk("pad_rvalid", ifc.right_valid, 1);
        chk("pad_lvalid", ifc.left_valid, 0);

        run_scan(0, 1'b1, -1, -1, 1'b0);
        chk_single("bp");

        run_scan(0, 1'b0, 5000, -1, 1'b0);
        @(negedge clock);
        chk("post_abort_done", ifc.done, 0);
        run_scan(0, 1'b0, -1, 0, 1'b0);
        chk_single("rerun");

        run_scan(3, 1'b0, -1, -1, 1'b0);
`ifdef HOUGH_VOTE_THRESH_EN
        chk("thr_lvalid", ifc.left_valid, 0);
        chk("thr_lrho", $signed(ifc.left_rho_out), 0);
        chk("thr_ltheta", ifc.left_theta_out, 0);
`else
        chk("thr_lvalid", ifc.left_valid, 1);
        chk("thr_lrho", $signed(ifc.left_rho_out), -412);
        chk("thr_ltheta", ifc.left_theta_out, 50);
`endif
        chk("thr_rvalid", ifc.right_valid, 1);
        chk("thr_rrho", $signed(ifc.right_rho_out), -12);
        chk("thr_rtheta", ifc.right_theta_out, 130);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
